hex_result_pager: RTL and testbench

- Upstream feeder for a row of 4-bit-to-7-segment hex digit decoders on the board.
- Captures a wide result word (e.g. a matrix-multiply/XOR result) through a valid/ready handshake and holds it.
- Presents one page of NUM_DIGITS nibbles at a time.
- Pages advance on a debounced push-button press (active-low board key), wrapping at the last page.

---
 rtl/hex_result_pager.sv | 133 +++++++++++++
 tb/tb_hex_result_pager.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/hex_result_pager.sv
// Holds a captured result word and pages it out NUM_DIGITS nibbles at a time; a debounced key press advances the page.
// Optional AUTO_PAGE_EN macro adds a periodic auto-advance timer. Outputs are registered, so they lag an accept or advance by one cycle.
module hex_result_pager #(
  parameter int DATA_W          = 32,
  parameter int NUM_DIGITS      = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int AUTO_TICKS      = 50000000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DATA_W-1:0]       data_in,
  input  logic                    data_valid,
  output logic                    in_ready,
  input  logic                    hold,
  input  logic                    key_n,
  output logic [4*NUM_DIGITS-1:0] digits_out,
  output logic [3:0]              page_idx,
  output logic                    loaded
);

  localparam int PAGE_W = 4 * NUM_DIGITS;
  localparam int PAGES  = DATA_W / PAGE_W;
  localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES);
  localparam logic [3:0]       LAST_PAGE = 4'(PAGES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2 || AUTO_TICKS < 1 || PAGES < 1 || PAGES > 16 ||
      DATA_W % PAGE_W != 0) begin : g_bad_cfg
    $error("hex_result_pager: illegal parameter combination");
  end

  typedef enum logic {EMPTY, SHOW} state_t;

  state_t             state_q, state_d;
  logic [DATA_W-1:0]  word_q, word_d;
  logic [3:0]         page_q, page_d;
  logic [PAGE_W-1:0]  digits_q, digits_d;
  logic               key_s1_q, key_s2_q;
  logic               key_db_q, key_db_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               press_q, press_d;
  logic               accept, advance, auto_adv;
  logic [PAGE_W-1:0]  page_word;

  assign in_ready   = rst_n & ~hold;
  assign accept     = data_valid & in_ready;
  assign digits_out = digits_q;
  assign page_idx   = page_q;
  assign loaded     = (state_q == SHOW);

`ifdef AUTO_PAGE_EN
  localparam int TMR_W = $clog2(AUTO_TICKS + 1);
  localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(AUTO_TICKS - 1);
  logic [TMR_W-1:0] timer_q, timer_d;

  always_comb begin
    timer_d  = timer_q;
    auto_adv = 1'b0;
    if (accept || press_q) begin
      timer_d = '0;
    end else if (state_q == SHOW && PAGES > 1) begin
      if (timer_q == TMR_MAX) begin
        timer_d  = '0;
        auto_adv = 1'b1;
      end else begin
        timer_d = timer_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) timer_q <= '0;
    else        timer_q <= timer_d;
  end
`else
  assign auto_adv = 1'b0;
`endif

  // Debounce: a level change is only taken after DEBOUNCE_CYCLES consecutive mismatches.
  always_comb begin
    key_db_d = key_db_q;
    cnt_d    = '0;
    if (key_s2_q != key_db_q) begin
      if (cnt_q == CNT_MAX) key_db_d = key_s2_q;
      else                  cnt_d    = cnt_q + 1'b1;
    end
    press_d = key_db_q & ~key_db_d;
  end

  always_comb begin
    advance = (state_q == SHOW) && (press_q || auto_adv);
    state_d = state_q;
    word_d  = word_q;
    page_d  = page_q;
    if (accept) begin
      state_d = SHOW;
      word_d  = data_in;
      page_d  = '0;
    end else if (advance) begin
      page_d = (page_q == LAST_PAGE) ? 4'd0 : page_q + 4'd1;
    end
    page_word = '0;
    for (int p = 0; p < PAGES; p++) begin
      if (page_d == 4'(p)) page_word = word_d[p*PAGE_W +: PAGE_W];
    end
    digits_d = (state_d == SHOW) ? page_word : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= EMPTY;
      word_q   <= '0;
      page_q   <= '0;
      digits_q <= '0;
      key_s1_q <= 1'b1;
      key_s2_q <= 1'b1;
      key_db_q <= 1'b1;
      cnt_q    <= '0;
      press_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      word_q   <= word_d;
      page_q   <= page_d;
      digits_q <= digits_d;
      key_s1_q <= key_n;
      key_s2_q <= key_s1_q;
      key_db_q <= key_db_d;
      cnt_q    <= cnt_d;
      press_q  <= press_d;
    end
  end

endmodule

// File: tb/tb_hex_result_pager.sv
// Directed bench for hex_result_pager with DEBOUNCE_CYCLES=4, default build (no auto paging).
module tb_hex_result_pager;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] data_in;
  logic        data_valid;
  logic        in_ready;
  logic        hold;
  logic        key_n;
  logic [15:0] digits_out;
  logic [3:0]  page_idx;
  logic        loaded;

  int errors = 0;
  int checks = 0;

  hex_result_pager #(
    .DATA_W(32), .NUM_DIGITS(4), .DEBOUNCE_CYCLES(4), .AUTO_TICKS(10)
  ) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .data_valid(data_valid),
    .in_ready(in_ready), .hold(hold), .key_n(key_n), .digits_out(digits_out),
    .page_idx(page_idx), .loaded(loaded)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input int low_cycles);
    key_n = 1'b0;
    step(low_cycles);
    key_n = 1'b1;
    step(20);
  endtask

  initial begin
    int first_adv;
    int n_adv;
    logic [3:0] prev_page;

    rst_n = 1'b0; key_n = 1'b1; hold = 1'b0; data_valid = 1'b0; data_in = '0;
    #2;
    check("rst_digits", 32'(digits_out), 32'h0);
    check("rst_page", 32'(page_idx), 32'h0);
    check("rst_loaded", 32'(loaded), 32'h0);
    check("rst_in_ready", 32'(in_ready), 32'h0);
    step(2);
    rst_n = 1'b1;
    step(2);

    data_in = 32'h1234_ABCD; data_valid = 1'b1;
    #1;
    check("in_ready_up", 32'(in_ready), 32'h1);
    step(1);
    data_valid = 1'b0;
    check("acc_digits", 32'(digits_out), 32'hABCD);
    check("acc_page", 32'(page_idx), 32'h0);
    check("acc_loaded", 32'(loaded), 32'h1);

    // Long press: exactly one advance, seen within 8 cycles.
    key_n = 1'b0; first_adv = -1; n_adv = 0; prev_page = page_idx;
    for (int i = 1; i <= 20; i++) begin
      step(1);
      if (page_idx != prev_page) begin
        n_adv++;
        if (first_adv < 0) first_adv = i;
      end
      prev_page = page_idx;
    end
    check("press_count", 32'(n_adv), 32'd1);
    check("press_latency_ok", 32'(first_adv >= 1 && first_adv <= 8), 32'h1);
    check("press_page", 32'(page_idx), 32'h1);
    check("press_digits", 32'(digits_out), 32'h1234);
    key_n = 1'b1;
    step(20);
    check("release_no_adv", 32'(page_idx), 32'h1);

    press(20);
    check("wrap_page", 32'(page_idx), 32'h0);
    check("wrap_digits", 32'(digits_out), 32'hABCD);

    for (int w = 1; w <= 3; w++) begin
      press(w);
      check($sformatf("glitch_%0d", w), 32'(page_idx), 32'h0);
    end

    hold = 1'b1; data_in = 32'hFFFF_0000; data_valid = 1'b1;
    #1;
    check("hold_in_ready", 32'(in_ready), 32'h0);
    step(3);
    check("hold_digits", 32'(digits_out), 32'hABCD);
    press(20);
    check("hold_press_page", 32'(page_idx), 32'h1);
    hold = 1'b0;
    step(1);
    data_valid = 1'b0;
    check("unhold_digits", 32'(digits_out), 32'h0000);
    check("unhold_page", 32'(page_idx), 32'h0);

    press(20);
    check("p1_digits", 32'(digits_out), 32'hFFFF);

    // Press pulse reaches the page logic on the 7th edge after key_n falls; accept on that same edge.
    key_n = 1'b0;
    step(6);
    data_in = 32'h5555_6666; data_valid = 1'b1;
    step(1);
    data_valid = 1'b0;
    check("coll_page", 32'(page_idx), 32'h0);
    check("coll_digits", 32'(digits_out), 32'h6666);
    step(10);
    key_n = 1'b1;
    step(20);
    check("coll_discard", 32'(page_idx), 32'h0);

    press(20);
    check("pre_rst_page", 32'(page_idx), 32'h1);
    key_n = 1'b0;
    step(3);
    #2 rst_n = 1'b0;
    #1;
    check("arst_digits", 32'(digits_out), 32'h0);
    check("arst_page", 32'(page_idx), 32'h0);
    check("arst_loaded", 32'(loaded), 32'h0);
    step(2);
    key_n = 1'b1;
    rst_n = 1'b1;
    data_in = 32'hCAFE_BEEF; data_valid = 1'b1;
    step(1);
    data_valid = 1'b0;
    step(20);
    check("post_rst_no_adv", 32'(page_idx), 32'h0);
    check("post_rst_digits", 32'(digits_out), 32'hBEEF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
